btb: RTL and testbench

- Branch target buffer in IF, alongside the local-history direction predictor.
- Looks up the fetch PC combinationally and returns a predicted target, a hit flag and an unconditional-jump flag. The fetch next-PC mux consumes these together with the predictor's br_take.
- Lookup metadata travels with the instruction to EX. The resolved outcome trains the buffer and flags target mispredictions.

---
 rtl/btb_pkg.sv | 30 +++
 rtl/btb_set_array.sv | 57 +++++
 rtl/btb.sv | 106 ++++++++++
 tb/tb_btb.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared geometry, entry and lookup-package types for the branch target buffer
package btb_pkg;

    localparam int s_idx       = 4;
    localparam int s_pc_offset = 2;
    localparam int s_tag       = 32 - s_idx - s_pc_offset;
    localparam int n_sets      = 1 << s_idx;

    typedef struct packed {
        logic             valid;
        logic [s_tag-1:0] tag;
        logic [31:0]      target;
        logic             uncond;
    } btb_entry_t;

    typedef struct packed {
        logic        hit;
        logic        way;
        logic [31:0] pred_target;
    } btb_pkg_t;

    function automatic logic [s_idx-1:0] pc_index(input logic [31:0] pc);
        return pc[s_idx+s_pc_offset-1:s_pc_offset];
    endfunction

    function automatic logic [s_tag-1:0] pc_tag(input logic [31:0] pc);
        return pc[31:s_idx+s_pc_offset];
    endfunction

endpackage

// File: rtl/btb_set_array.sv
// rtl/btb_set_array.sv - 2-way BTB storage with one write port, a full-entry read port
// for fetch and a valid/tag/LRU read port for the EX-side allocation decision
module btb_set_array
    import btb_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [s_idx-1:0]           i_ra_idx,
    output btb_entry_t [1:0]           o_ra_entry,
    input  logic [s_idx-1:0]           i_rb_idx,
    output logic [1:0]                 o_rb_valid,
    output logic [1:0][s_tag-1:0]      o_rb_tag,
    output logic                       o_rb_lru,
    input  logic                       i_we,
    input  logic                       i_we_tag,
    input  logic [s_idx-1:0]           i_w_idx,
    input  logic                       i_w_way,
    input  btb_entry_t                 i_w_entry
);

    logic [n_sets-1:0][1:0] r_valid;
    logic [n_sets-1:0][1:0] r_uncond;
    logic [n_sets-1:0]      r_lru;
    logic [s_tag-1:0]       r_tag    [n_sets][2];
    logic [31:0]            r_target [n_sets][2];

    // LRU names the victim way, so the way just written becomes the other one's victim.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_lru   <= '0;
        end else if (i_we) begin
            if (i_we_tag)
                r_valid[i_w_idx][i_w_way] <= i_w_entry.valid;
            r_lru[i_w_idx] <= ~i_w_way;
        end
    end

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_target[i_w_idx][i_w_way] <= i_w_entry.target;
            r_uncond[i_w_idx][i_w_way] <= i_w_entry.uncond;
            if (i_we_tag)
                r_tag[i_w_idx][i_w_way] <= i_w_entry.tag;
        end
    end

    for (genvar w = 0; w < 2; w++) begin : g_rd
        assign o_ra_entry[w] = {r_valid[i_ra_idx][w], r_tag[i_ra_idx][w],
                                r_target[i_ra_idx][w], r_uncond[i_ra_idx][w]};
        assign o_rb_tag[w]   = r_tag[i_rb_idx][w];
    end

    assign o_rb_valid = r_valid[i_rb_idx];
    assign o_rb_lru   = r_lru[i_rb_idx];

endmodule

// File: rtl/btb.sv
// rtl/btb.sv - branch target buffer: 0-cycle fetch lookup with write bypass,
// IF->ID->EX metadata pipeline and EX-side training / target-mispredict flag
module btb
    import btb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_id,
    input  logic        stall_ex,
    input  logic [31:0] addr,
    output logic        hit,
    output logic [31:0] pred_target,
    output logic        pred_uncond,
    input  logic        update,
    input  logic [31:0] ex_pc,
    input  logic        br_en,
    input  logic [31:0] br_target,
    input  logic        is_uncond,
    output logic        tgt_mispred
);

    logic [s_idx-1:0]      w_if_idx, w_ex_idx;
    logic [s_tag-1:0]      w_if_tag, w_ex_tag;
    btb_entry_t [1:0]      w_arr_e, w_if_e;
    logic [1:0]            w_ex_valid, w_ex_match, w_if_match;
    logic [1:0][s_tag-1:0] w_ex_rtag;
    logic                  w_lru, w_wr, w_alloc, w_way;
    btb_entry_t            w_new;
    btb_pkg_t              w_if_pkg, r_id, r_ex;

    assign w_if_idx = pc_index(addr);
    assign w_if_tag = pc_tag(addr);
    assign w_ex_idx = pc_index(ex_pc);
    assign w_ex_tag = pc_tag(ex_pc);

    btb_set_array u_array (
        .clk        (clk),
        .rst        (rst),
        .i_ra_idx   (w_if_idx),
        .o_ra_entry (w_arr_e),
        .i_rb_idx   (w_ex_idx),
        .o_rb_valid (w_ex_valid),
        .o_rb_tag   (w_ex_rtag),
        .o_rb_lru   (w_lru),
        .i_we       (w_wr),
        .i_we_tag   (w_alloc),
        .i_w_idx    (w_ex_idx),
        .i_w_way    (w_way),
        .i_w_entry  (w_new)
    );

    assign w_wr        = update & br_en & ~rst;
    assign tgt_mispred = w_wr & (~r_ex.hit | (r_ex.pred_target != br_target));
    assign w_new       = {1'b1, w_ex_tag, br_target, is_uncond};

    for (genvar w = 0; w < 2; w++) begin : g_match
        assign w_ex_match[w] = w_ex_valid[w] & (w_ex_rtag[w] == w_ex_tag);
        assign w_if_match[w] = w_if_e[w].valid & (w_if_e[w].tag == w_if_tag);
    end

    // A miss in EX re-checks the set first: a stale package must not duplicate a tag.
    always_comb begin
        w_way   = 1'b0;
        w_alloc = 1'b0;
        if (r_ex.hit) begin
            w_way = r_ex.way;
        end else begin
            w_alloc = w_wr;
            if (w_ex_match[0])       w_way = 1'b0;
            else if (w_ex_match[1])  w_way = 1'b1;
            else if (!w_ex_valid[0]) w_way = 1'b0;
            else if (!w_ex_valid[1]) w_way = 1'b1;
            else                     w_way = w_lru;
        end
    end

    always_comb begin
        w_if_e = w_arr_e;
        if (w_wr && (w_if_idx == w_ex_idx)) begin
            w_if_e[w_way].target = br_target;
            w_if_e[w_way].uncond = is_uncond;
            if (w_alloc) begin
                w_if_e[w_way].valid = 1'b1;
                w_if_e[w_way].tag   = w_ex_tag;
            end
        end
    end

    assign hit         = |w_if_match;
    assign pred_target = w_if_match[0] ? w_if_e[0].target :
                         w_if_match[1] ? w_if_e[1].target : 32'h0;
    assign pred_uncond = (w_if_match[0] & w_if_e[0].uncond) |
                         (w_if_match[1] & w_if_e[1].uncond);
    assign w_if_pkg    = {hit, w_if_match[1], pred_target};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id <= '0;
            r_ex <= '0;
        end else begin
            if (!stall_id) r_id <= w_if_pkg;
            if (!stall_ex) r_ex <= r_id;
        end
    end

endmodule

// File: tb/tb_btb.sv
// tb/tb_btb.sv - randomized scoreboard bench for btb with directed scenarios
module tb_btb;

    logic        clk = 1'b0;
    logic        rst, stall_id, stall_ex, update, br_en, is_uncond;
    logic [31:0] addr, ex_pc, br_target;
    logic        hit, pred_uncond, tgt_mispred;
    logic [31:0] pred_target;

    btb dut (
        .clk(clk), .rst(rst), .stall_id(stall_id), .stall_ex(stall_ex),
        .addr(addr), .hit(hit), .pred_target(pred_target), .pred_uncond(pred_uncond),
        .update(update), .ex_pc(ex_pc), .br_en(br_en), .br_target(br_target),
        .is_uncond(is_uncond), .tgt_mispred(tgt_mispred)
    );

    always #5 clk = ~clk;

    typedef struct { bit hit; bit way; logic [31:0] tgt; } pk_t;
    typedef struct { bit hit; logic [31:0] tgt; bit unc; bit mis; } exp_t;

    exp_t        q[$];
    bit          mv [16][2];
    logic [25:0] mt [16][2];
    logic [31:0] mg [16][2];
    bit          mu [16][2];
    bit          ml [16];
    pk_t         m_id, m_ex, m_if;
    bit          p_sid, p_sex;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic [31:0] pool [8] = '{32'h100, 32'h140, 32'h180, 32'h1C0,
                              32'h104, 32'h144, 32'h184, 32'h8000_0104};
    logic [31:0] tpool [4] = '{32'h200, 32'h300, 32'h400, 32'h500};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int s = 0; s < 16; s++) begin
            ml[s] = 0;
            for (int k = 0; k < 2; k++) mv[s][k] = 0;
        end
        m_id = '{default: 0};
        m_ex = '{default: 0};
        m_if = '{default: 0};
    endtask

    task automatic lookup(input logic [31:0] a, output pk_t p, output bit u);
        int s;
        s = int'((a >> 2) & 32'hF);
        p = '{default: 0};
        u = 0;
        for (int k = 0; k < 2; k++)
            if (mv[s][k] && mt[s][k] == a[31:6]) begin
                p.hit = 1; p.way = (k == 1); p.tgt = mg[s][k]; u = mu[s][k];
            end
    endtask

    task automatic step(input logic [31:0] a, input bit u, input logic [31:0] pc, input bit be,
                        input logic [31:0] bt, input bit un, input bit sid, input bit sex);
        exp_t e;
        int   s, w;
        bit   mis, uc;
        @(posedge clk);
        if (!p_sex) m_ex = m_id;
        if (!p_sid) m_id = m_if;
        p_sid = sid;
        p_sex = sex;
        #1;
        addr = a; update = u; ex_pc = pc; br_en = be; br_target = bt;
        is_uncond = un; stall_id = sid; stall_ex = sex;
        mis = 0;
        if (u && be) begin
            s   = int'((pc >> 2) & 32'hF);
            mis = !m_ex.hit || (m_ex.tgt != bt);
            if (m_ex.hit) begin
                w = m_ex.way ? 1 : 0;
            end else begin
                w = -1;
                for (int k = 0; k < 2; k++) if (mv[s][k] && mt[s][k] == pc[31:6]) w = k;
                if (w < 0) for (int k = 1; k >= 0; k--) if (!mv[s][k]) w = k;
                if (w < 0) w = ml[s] ? 1 : 0;
                mv[s][w] = 1;
                mt[s][w] = pc[31:6];
            end
            mg[s][w] = bt;
            mu[s][w] = un;
            ml[s]    = (w == 0);
        end
        lookup(a, m_if, uc);
        e.hit = m_if.hit; e.tgt = m_if.tgt; e.unc = uc; e.mis = mis;
        q.push_back(e);
    endtask

    task automatic idle(input logic [31:0] a);
        step(a, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic upd(input logic [31:0] a, input logic [31:0] pc, input bit be,
                       input logic [31:0] bt, input bit un);
        step(a, 1, pc, be, bt, un, 0, 0);
    endtask

    task automatic reset_async();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_hit",         {31'b0, hit},         32'h0);
        chk("rst_pred_target", pred_target,          32'h0);
        chk("rst_pred_uncond", {31'b0, pred_uncond}, 32'h0);
        chk("rst_tgt_mispred", {31'b0, tgt_mispred}, 32'h0);
        @(posedge clk);
        #1;
        update = 1'b0;
        rst    = 1'b0;
        model_clear();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("sb_hit",         {31'b0, hit},         {31'b0, e.hit});
                chk("sb_pred_target", pred_target,          e.tgt);
                chk("sb_pred_uncond", {31'b0, pred_uncond}, {31'b0, e.unc});
                chk("sb_tgt_mispred", {31'b0, tgt_mispred}, {31'b0, e.mis});
            end
        end
    end

    initial begin
        logic [31:0] ra, rpc, rbt;
        rst = 1'b1; stall_id = 0; stall_ex = 0; update = 0; br_en = 0; is_uncond = 0;
        addr = 0; ex_pc = 0; br_target = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        idle(32'h60);
        @(negedge clk); chk("reset_lookup_hit", {31'b0, hit}, 32'h0);
        chk("reset_lookup_tgt", pred_target, 32'h0);
        upd(32'h60, 32'h100, 1, 32'h200, 0);
        @(negedge clk); chk("alloc_mispred", {31'b0, tgt_mispred}, 32'h1);
        idle(32'h100);
        @(negedge clk); chk("alloc_hit", {31'b0, hit}, 32'h1);
        chk("alloc_tgt", pred_target, 32'h200);
        chk("alloc_uncond", {31'b0, pred_uncond}, 32'h0);

        reset_async();
        upd(32'h100, 32'h100, 1, 32'h200, 0);
        @(negedge clk); chk("bypass_hit", {31'b0, hit}, 32'h1);
        chk("bypass_tgt", pred_target, 32'h200);

        reset_async();
        upd(32'h60, 32'h100, 1, 32'h200, 0);
        upd(32'h100, 32'h140, 1, 32'h240, 0);
        idle(32'h60);
        upd(32'h60, 32'h100, 1, 32'h200, 0);
        @(negedge clk); chk("ex_hit_same_tgt", {31'b0, tgt_mispred}, 32'h0);
        upd(32'h60, 32'h180, 1, 32'h280, 1);
        @(negedge clk); chk("evict_alloc_mispred", {31'b0, tgt_mispred}, 32'h1);
        idle(32'h100);
        @(negedge clk); chk("lru_keep_100", pred_target, 32'h200);
        idle(32'h180);
        @(negedge clk); chk("lru_new_180", pred_target, 32'h280);
        chk("lru_new_180_unc", {31'b0, pred_uncond}, 32'h1);
        idle(32'h140);
        @(negedge clk); chk("lru_evicted_140", {31'b0, hit}, 32'h0);

        idle(32'h100);
        idle(32'h60);
        upd(32'h60, 32'h100, 1, 32'h300, 0);
        @(negedge clk); chk("tgt_change_mispred", {31'b0, tgt_mispred}, 32'h1);
        idle(32'h100);
        @(negedge clk); chk("tgt_change_new", pred_target, 32'h300);
        idle(32'h60);
        upd(32'h60, 32'h100, 0, 32'h500, 0);
        @(negedge clk); chk("not_taken_mispred", {31'b0, tgt_mispred}, 32'h0);
        idle(32'h100);
        @(negedge clk); chk("not_taken_keep", pred_target, 32'h300);

        upd(32'h60, 32'h204, 1, 32'h900, 1);
        step(32'h100, 0, 32'h0, 0, 32'h0, 0, 0, 1);
        step(32'h100, 1, 32'h300, 1, 32'h700, 0, 0, 1);
        reset_async();
        idle(32'h100);
        @(negedge clk); chk("post_rst_100", {31'b0, hit}, 32'h0);
        idle(32'h180);
        @(negedge clk); chk("post_rst_180", {31'b0, hit}, 32'h0);
        idle(32'h204);
        @(negedge clk); chk("post_rst_204", {31'b0, hit}, 32'h0);
        idle(32'h300);
        @(negedge clk); chk("post_rst_300", {31'b0, hit}, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            ra  = ($urandom_range(0, 9) == 0) ? $urandom : pool[$urandom_range(0, 7)];
            rpc = pool[$urandom_range(0, 7)];
            rbt = tpool[$urandom_range(0, 3)];
            step(ra, $urandom_range(0, 1) == 1, rpc, $urandom_range(0, 3) != 0, rbt,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
            if (i == 1500) reset_async();
        end
        idle(32'h60);
        @(negedge clk);
        #1;
        chk("sb_drained", q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
